// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Owns the six BCD digits of a 24 h clock. In RUN the time advances on a
// 1 Hz tick; two debounced push-buttons walk through SET_H / SET_M / SET_S
// and adjust the selected field, while the selected digit pair blinks via a
// per-digit blank mask that the display top level ANDs into its digit enables.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst       in   asynchronous, active-high reset
//   tick_1hz  in   one-cycle pulse per second, synchronous to clk
//   btn_mode  in   raw mode button (asynchronous, 1 = pressed)
//   btn_inc   in   raw increment button (asynchronous, 1 = pressed)
//   seconds, t_secs, minutes, t_mins, hours, t_hours
//             out  registered BCD time digits
//   blank     out  registered per-digit blank, 1 = blank
//                  bit0 seconds .. bit5 t_hours
//   mode      out  FSM state, 00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
//                  (this is the state register itself, so it doubles as the
//                  FSM debug view)
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_CYCLES    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] seconds,
    output logic [3:0] t_secs,
    output logic [3:0] minutes,
    output logic [3:0] t_mins,
    output logic [3:0] hours,
    output logic [3:0] t_hours,
    output logic [5:0] blank,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10,
        ST_SET_S = 2'b11
    } state_e;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    // Blank patterns for each editable digit pair.
    localparam logic [5:0] BLANK_H = 6'b110000;
    localparam logic [5:0] BLANK_M = 6'b001100;
    localparam logic [5:0] BLANK_S = 6'b000011;

    // -------------------------------------------------------------------------
    // Button conditioning: index 0 = mode, index 1 = inc.
    // Each button: 2-FF synchronizer, then a stability counter that runs only
    // while the synchronized level disagrees with the accepted level and is
    // cleared as soon as they agree again, so any bounce shorter than
    // DEBOUNCE_CYCLES restarts the count. The press pulse is emitted in the
    // same cycle the accepted level rises, so a held button pulses once and a
    // release never pulses.
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_inc, btn_mode};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            level_q;
        logic            press_q;
        logic [DB_W-1:0] cnt_q;
        logic            level_d;
        logic            press_d;
        logic [DB_W-1:0] cnt_d;

        always_comb begin
            level_d = level_q;
            press_d = 1'b0;
            cnt_d   = '0;
            if (sync2_q != level_q) begin
                if (cnt_q == DB_LAST) begin
                    level_d = sync2_q;
                    press_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_raw[b];
                sync2_q <= sync1_q;
                level_q <= level_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign press[b] = press_q;
    end

    logic mode_press;
    logic inc_press;

    assign mode_press = press[0];
    assign inc_press  = press[1];

    // -------------------------------------------------------------------------
    // BCD pair arithmetic. Digit pairs are kept as {tens, units} bytes so the
    // legal values read naturally in hex (8'h23, 8'h59).
    // -------------------------------------------------------------------------
    function automatic logic [7:0] sexa_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] hours_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Main state
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [7:0]      hh_q, hh_d;
    logic [7:0]      mm_q, mm_d;
    logic [7:0]      ss_q, ss_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;   // 1 = blanked half of the blink
    logic [5:0]      blank_q, blank_d;

    always_comb begin
        state_d     = state_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = '0;

        // Time only advances from RUN. A tick that coincides with the
        // RUN -> SET_H press is still applied because it is decided on the
        // current state; a tick coinciding with SET_S -> RUN is dropped.
        if (state_q == ST_RUN && tick_1hz) begin
            ss_d = sexa_inc(ss_q);
            if (ss_q == 8'h59) begin
                mm_d = sexa_inc(mm_q);
                if (mm_q == 8'h59) begin
                    hh_d = hours_inc(hh_q);
                end
            end
        end

        // Mode press wins over a simultaneous inc press.
        if (mode_press) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                default:  state_d = ST_RUN;
            endcase
        end else if (inc_press) begin
            case (state_q)
                ST_SET_H: hh_d = hours_inc(hh_q);
                ST_SET_M: mm_d = sexa_inc(mm_q);
                ST_SET_S: ss_d = 8'h00;
                default:  ;
            endcase
        end

        // Blink timer: idle in RUN, restarted visible on every mode change
        // and on every inc press so an edited value shows up at once.
        if (state_q == ST_RUN || mode_press || inc_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // The mask is built from next-state values so it lines up with the
        // digits it belongs to in the same cycle.
        if (phase_d) begin
            case (state_d)
                ST_SET_H: blank_d = BLANK_H;
                ST_SET_M: blank_d = BLANK_M;
                ST_SET_S: blank_d = BLANK_S;
                default:  blank_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
        end
    end

    assign seconds = ss_q[3:0];
    assign t_secs  = ss_q[7:4];
    assign minutes = mm_q[3:0];
    assign t_mins  = mm_q[7:4];
    assign hours   = hh_q[3:0];
    assign t_hours = hh_q[7:4];
    assign blank   = blank_q;
    assign mode    = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl: directed test of clock_set_ctrl with DEBOUNCE_CYCLES=4 and
// BLINK_CYCLES=8. Time is compared as a 24-bit BCD word HHMMSS written in hex.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int DB = 4;
    localparam int BL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic tick_1hz;
    logic btn_mode;
    logic btn_inc;
    logic [3:0] seconds, t_secs, minutes, t_mins, hours, t_hours;
    logic [5:0] blank;
    logic [1:0] mode;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_CYCLES   (BL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1hz(tick_1hz),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .seconds (seconds),
        .t_secs  (t_secs),
        .minutes (minutes),
        .t_mins  (t_mins),
        .hours   (hours),
        .t_hours (t_hours),
        .blank   (blank),
        .mode    (mode)
    );

    logic [23:0] time_now;
    assign time_now = {t_hours, hours, t_mins, minutes, t_secs, seconds};

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clean press: hold long enough for debounce + landing, then release
    // long enough for the release to debounce too.
    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    task automatic run_ticks(input int n);
        @(negedge clk);
        tick_1hz = 1'b1;
        repeat (n) @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] exp_blank;

        rst      = 1'b1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_time", time_now, 24'h000000);
        check("reset_mode", mode, 2'b00);
        check("reset_blank", blank, 6'b000000);
        rst = 1'b0;
        @(negedge clk);

        // 1. A full day of ticks, one per cycle.
        tick_1hz = 1'b1;
        repeat (35999) @(negedge clk);
        check("run_095959", time_now, 24'h095959);
        @(negedge clk);
        check("run_100000", time_now, 24'h100000);
        repeat (50399) @(negedge clk);
        check("run_235959", time_now, 24'h235959);
        @(negedge clk);
        tick_1hz = 1'b0;
        check("run_wrap_000000", time_now, 24'h000000);
        check("run_mode", mode, 2'b00);
        check("run_blank", blank, 6'b000000);

        // 2. Bouncing mode button, then held.
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        repeat (2) @(negedge clk);
        btn_mode = 1'b1;
        check("bounce_no_press", mode, 2'b00);
        repeat (20) @(negedge clk);
        check("held_one_press", mode, 2'b01);
        repeat (20) @(negedge clk);
        check("held_no_repeat", mode, 2'b01);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        check("release_no_press", mode, 2'b01);

        // 3. Hours editing.
        press_inc_n(23);
        check("seth_23", time_now, 24'h230000);
        press_inc_n(1);
        check("seth_wrap_00", time_now, 24'h000000);
        press_inc_n(10);
        check("seth_10", time_now, 24'h100000);
        press_inc_n(19);
        check("seth_05", time_now, 24'h050000);
        press(1'b1, 1'b0);
        check("mode_seth_to_setm", mode, 2'b10);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("mode_back_run", mode, 2'b00);
        check("run_time_kept", time_now, 24'h050000);
        press(1'b0, 1'b1);
        check("run_inc_ignored", time_now, 24'h050000);
        run_ticks(37);
        check("run_050037", time_now, 24'h050037);

        // 4. Minutes editing, ticks frozen.
        press(1'b1, 1'b0);
        check("mode_seth", mode, 2'b01);
        press(1'b1, 1'b0);
        check("mode_setm", mode, 2'b10);
        press_inc_n(59);
        check("setm_59", time_now, 24'h055937);
        press_inc_n(1);
        check("setm_wrap_no_carry", time_now, 24'h050037);
        run_ticks(5);
        @(negedge clk);
        check("setm_ticks_dropped", time_now, 24'h050037);

        // 5. SET_S blink and inc mid-blank. Mode change lands at edge E; the
        //    sample after E is i=0. An inc raised at sample 18 lands at 25.
        @(negedge clk);
        btn_mode = 1'b1;
        for (int k = 0; k < 30 && mode != 2'b11; k++) @(negedge clk);
        check("mode_sets", mode, 2'b11);
        for (int i = 0; i < 34; i++) begin
            if (i < 25) exp_blank = ((i / 8) % 2 == 1) ? 6'b000011 : 6'b000000;
            else        exp_blank = (((i - 25) / 8) % 2 == 1) ? 6'b000011 : 6'b000000;
            check($sformatf("sets_blank_i%0d", i), blank, exp_blank);
            if (i == 24) check("sets_before_inc", time_now, 24'h050037);
            if (i == 25) check("sets_inc_clears", time_now, 24'h050000);
            if (i == 18) btn_inc = 1'b1;
            @(negedge clk);
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
        press(1'b1, 1'b0);
        check("sets_to_run", mode, 2'b00);
        check("sets_to_run_blank", blank, 6'b000000);
        check("sets_to_run_time", time_now, 24'h050000);

        // 6. Simultaneous mode+inc, then async reset mid-SET_M.
        press(1'b1, 1'b0);
        press_inc_n(2);
        check("seth_07", time_now, 24'h070000);
        press(1'b1, 1'b1);
        check("simul_mode_wins", mode, 2'b10);
        check("simul_inc_dropped", time_now, 24'h070000);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_time", time_now, 24'h000000);
        check("async_rst_mode", mode, 2'b00);
        check("async_rst_blank", blank, 6'b000000);
        btn_inc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_full_debounce", mode, 2'b00);
        repeat (5) @(negedge clk);
        check("post_rst_press", mode, 2'b01);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Owns the six BCD time digits of the 24 h clock and sequences them. In RUN mode the digits advance on a 1 Hz tick. Two push-buttons select a field (hours, minutes, seconds) and adjust it. The selected digit pair blinks through a per-digit blank mask, which the top level ANDs into the 7-segment digit enables. The block sits between the 1 Hz prescaler/buttons and the display refresh multiplexer.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles a synchronized button level must hold stable before it is accepted (10 ms at 50 MHz)
BLINK_CYCLES, 25000000, half-period of the set-mode blink in clk cycles (0.5 s at 50 MHz)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-cycle pulse, once per second, synchronous to clk
btn_mode  input  1  raw mode button, asynchronous, 1 = pressed
btn_inc  input  1  raw increment button, asynchronous, 1 = pressed
seconds, t_secs, minutes, t_mins, hours, t_hours  output  4 each  BCD time digits, registered
blank  output  6  per-digit blank, 1 = blank; bit0 seconds, bit1 t_secs, bit2 minutes, bit3 t_mins, bit4 hours, bit5 t_hours
mode  output  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S

Behaviour:
- Reset (async assert):
  - all digits 0; mode = RUN; blank = 000000
  - sync flops, debounce counters and debounced levels = 0 (released)
  - blink counter and blink phase = 0
- Button path, per button:
  - 2-FF synchronizer, then a counter that restarts whenever the synchronized level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A 0->1 transition of the debounced level emits a one-cycle press pulse. A held button gives exactly one pulse. Release gives no pulse.
  - Bounces shorter than DEBOUNCE_CYCLES give no pulse.
- Press latency: an effect lands on outputs 1 cycle after the press pulse. Total latency from a clean raw edge = 2 + DEBOUNCE_CYCLES + 2 cycles, ±1.
- FSM: RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing on each mode press.
- RUN:
  - tick_1hz advances the time: seconds 0-9, t_secs 0-5, minutes 0-9, t_mins 0-5, hours 0-9, t_hours 0-2.
  - Hours pair wraps 23 -> 00, so 23:59:59 + tick = 00:00:00. Carries ripple in the same cycle.
  - Inc presses are ignored.
- SET_H / SET_M / SET_S:
  - tick_1hz is dropped, not queued; time is frozen.
  - SET_H inc: hours pair +1 mod 24 (09 -> 10, 19 -> 20, 23 -> 00).
  - SET_M inc: minutes pair +1 mod 60 (59 -> 00), no carry into hours.
  - SET_S inc: seconds pair cleared to 00 (no carry).
- Simultaneous events:
  - Mode and inc pulses in the same cycle: mode wins, inc discarded.
  - In RUN, tick with any press: tick applies, mode still advances.
  - A tick in the same cycle as the RUN -> SET_H transition is applied. A tick in the same cycle as SET_S -> RUN is dropped.
- Blink:
  - The counter counts only in SET states.
  - On any mode change the counter = 0 and phase = visible.
  - The counter wraps at BLINK_CYCLES - 1 and toggles the phase.
  - Each inc press resets the counter and forces phase visible, so the edited value is visible immediately.
- blank:
  - Registered.
  - RUN: 000000.
  - SET_H: 110000, SET_M: 001100, SET_S: 000011, each only during the blanked phase; otherwise 000000.
- Digits are always valid BCD and always a valid time. No illegal encodings are reachable from reset.
- Reset asserted mid-debounce or mid-set returns immediately to the reset state. The first press after release needs a full debounce.

Test Plan:
(bench uses DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
1. After reset, 86400 tick_1hz pulses in RUN -> time advances through 23:59:59 and returns to 00:00:00; spot-check 09:59:59 -> 10:00:00 on the next tick.
2. Raw btn_mode bounce (1-0-1 with 2-cycle gaps) then held high 20 cycles -> exactly one press: mode 00 -> 01; further holding causes no change.
3. SET_H at 23, one inc press -> 00. Then 10 presses -> 10. Three mode presses -> RUN with minutes/seconds unchanged.
4. SET_M at 59 with hours 05, inc -> minutes 00, hours 05. tick_1hz pulses during SET_M -> time unchanged.
5. SET_S, blank observed: 000011 for 8 cycles, 000000 for 8, repeating. Inc press mid-blank -> seconds 00 and blank 000000 the next cycle.
6. Mode and inc pulses in the same cycle in SET_H (hours 07) -> mode 10, hours stay 07. Async rst mid-SET_M -> all outputs reset without waiting for a clk edge.
